// File: rtl/mem_access_ctrl.sv
// Request sequencer between the CPU MAR/MDR side and a synchronous single-port RAM.
// Issues one registered RAM strobe per legal request, absorbs read latency, pulses done/err.
module mem_access_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int CPU_ADDR_WIDTH = 32,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  input  logic                      req_write,
  input  logic [CPU_ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  output logic                      req_ready,
  output logic                      done,
  output logic                      err,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [ADDR_WIDTH-1:0]     ram_addr,
  output logic [DATA_WIDTH-1:0]     ram_din,
  output logic                      ram_we,
  output logic                      ram_re,
  input  logic [DATA_WIDTH-1:0]     ram_dout,
  output logic [CNT_WIDTH-1:0]      rd_count,
  output logic [CNT_WIDTH-1:0]      wr_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_CAPTURE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                  r_done;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [DATA_WIDTH-1:0] r_ram_din;
  logic                  r_ram_we;
  logic                  r_ram_re;
  logic [CNT_WIDTH-1:0]  r_rd_count;
  logic [CNT_WIDTH-1:0]  r_wr_count;

  logic w_accept;
  logic w_addr_oor;

  assign w_accept   = req_valid && (r_state == S_IDLE);
  assign w_addr_oor = |req_addr[CPU_ADDR_WIDTH-1:ADDR_WIDTH];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: next state takes a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_accept && !w_addr_oor) w_state_nxt = S_ACCESS;
      // The write strobe is still up during ACCESS, so it identifies the operation.
      S_ACCESS:  w_state_nxt = r_ram_we ? S_IDLE : S_CAPTURE;
      S_CAPTURE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
      r_ram_we   <= 1'b0;
      r_ram_re   <= 1'b0;
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_addr_oor) begin
              r_done <= 1'b1;
              r_err  <= 1'b1;
            end else begin
              r_ram_addr <= req_addr[ADDR_WIDTH-1:0];
              r_ram_din  <= req_wdata;
              r_ram_we   <= req_write;
              r_ram_re   <= !req_write;
            end
          end
        end
        S_ACCESS: begin
          r_ram_we <= 1'b0;
          r_ram_re <= 1'b0;
          if (r_ram_we) begin
            r_done     <= 1'b1;
            r_wr_count <= r_wr_count + 1'b1;
          end
        end
        S_CAPTURE: begin
          r_rdata    <= ram_dout;
          r_done     <= 1'b1;
          r_rd_count <= r_rd_count + 1'b1;
        end
        default: begin
          r_ram_we <= 1'b0;
          r_ram_re <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign done      = r_done;
  assign err       = r_err;
  assign rdata     = r_rdata;
  assign ram_addr  = r_ram_addr;
  assign ram_din   = r_ram_din;
  assign ram_we    = r_ram_we;
  assign ram_re    = r_ram_re;
  assign rd_count  = r_rd_count;
  assign wr_count  = r_wr_count;

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequencer between the CPU control unit (MAR/MDR side) and the synchronous single-port RAM.
- Accepts one read or write request at a time over a valid/ready handshake and drives registered RAM control (address, data-in, write_enable, read_enable).
- Absorbs the RAM's 1-cycle read latency into a held read-data register and returns a one-cycle done pulse.
- Rejects out-of-range addresses without touching the RAM, and keeps wrapping read/write access counters for bench visibility.

Parameters:
- DATA_WIDTH, 32, width of data words on both the CPU and RAM sides.
- ADDR_WIDTH, 8, RAM address width; legal CPU addresses are 0 to 2^ADDR_WIDTH-1.
- CPU_ADDR_WIDTH, 32, width of the address presented by the CPU (MAR width).
- CNT_WIDTH, 16, width of the access counters.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  CPU request present.
- req_write  input  1  1 = write, 0 = read; sampled with req_valid.
- req_addr  input  CPU_ADDR_WIDTH  request address.
- req_wdata  input  DATA_WIDTH  write data.
- req_ready  output  1  controller can accept a request this cycle.
- done  output  1  one-cycle completion pulse.
- err  output  1  one-cycle pulse coincident with done; the address was out of range.
- rdata  output  DATA_WIDTH  last successfully read word; held until the next read completes.
- ram_addr  output  ADDR_WIDTH  to RAM address.
- ram_din  output  DATA_WIDTH  to RAM data-in.
- ram_we  output  1  to RAM write_enable.
- ram_re  output  1  to RAM read_enable.
- ram_dout  input  DATA_WIDTH  from RAM data-out (valid the cycle after the edge at which ram_re was sampled).
- rd_count  output  CNT_WIDTH  completed reads.
- wr_count  output  CNT_WIDTH  completed writes.

Behaviour:
- Reset (synchronous, wins over everything):
  - state=IDLE.
  - done, err, ram_we, ram_re = 0.
  - ram_addr, ram_din, rdata, rd_count, wr_count = 0.
  - req_ready = 1 in the cycle after reset.
- States: IDLE, ACCESS, CAPTURE. req_ready = (state==IDLE), combinational from state. All other outputs are registered.
- done and err default to 0 every edge unless set below.
- IDLE:
  - Handshake when req_valid && req_ready at edge E0.
  - Out of range (any of req_addr[CPU_ADDR_WIDTH-1:ADDR_WIDTH] nonzero): done=1, err=1 after E0. No RAM strobe. rdata and counters unchanged. Stay IDLE.
  - Otherwise: ram_addr <= req_addr[ADDR_WIDTH-1:0]; ram_din <= req_wdata; ram_we <= req_write; ram_re <= !req_write; go ACCESS.
  - If req_valid is low, hold.
- ACCESS (RAM samples its strobes at edge E1):
  - ram_we <= 0, ram_re <= 0.
  - Write: done=1, wr_count += 1 (wraps modulo 2^CNT_WIDTH), go IDLE.
  - Read: go CAPTURE.
- CAPTURE (edge E2): rdata <= ram_dout; done=1; rd_count += 1 (wraps); go IDLE.
- Latency from acceptance edge to done high: write 1 cycle, read 2 cycles, error 1 cycle.
- Exactly one strobe is high for exactly one cycle per legal request. ram_we and ram_re are never high together.
- Back-to-back: the done cycle is an IDLE cycle, so a new request is accepted at the edge ending the done cycle. Sustained throughput: 1 write per 2 cycles, 1 read per 3 cycles.
- While not IDLE, req_* inputs are ignored. The CPU must hold req_valid until it sees the handshake.
- Reset during ACCESS: the strobe already registered is still seen by the RAM at that edge, so a write completes in RAM. The controller drops done, resets counters and returns to IDLE.
- Reset during CAPTURE: rdata is cleared to 0, not loaded.
- Address boundary: 2^ADDR_WIDTH-1 is legal; 2^ADDR_WIDTH is an error.

Test Plan:
- Reset then idle → req_ready=1; done, err, ram_we, ram_re, rdata and counters all 0.
- Write addr 0x54, data 0x00000097 → ram_we=1 for one cycle with ram_addr=0x54; done 1 cycle after accept; wr_count=1. Then read 0x54 → ram_re pulse; done 2 cycles after accept; rdata=0x00000097; rd_count=1.
- Write 0x92 = 0x46 with req_valid held high, followed by a read of 0x92 → second accept on the edge ending the done cycle; rdata=0x46; ram_we and ram_re never both 1.
- Read addr 0x100 → done=1 and err=1 one cycle after accept; no RAM strobe; rdata keeps its prior value. Read addr 0xFF → legal, no err.
- Issue a write then assert reset in the ACCESS cycle → RAM location written; done never pulses; counters 0; req_ready=1 the next cycle. Repeat the case with a read reset in CAPTURE → rdata=0.
- Preload wr_count near wrap via 2^CNT_WIDTH writes (or a reduced CNT_WIDTH=4 build doing 16 writes) → count wraps to 0 with no other effect.
